// File: rtl/uart_tx_cfg_if.sv
// Handshake bundle between the TX FIFO / baud generator / line and the
// configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8
);
  logic              s_tick;
  logic              tx_start;
  logic [DATA_W-1:0] tx_din;
  logic [3:0]        cfg_dbits;
  logic [1:0]        cfg_parity;
  logic [1:0]        cfg_stop;
  logic              tx_break;
  logic              tx_fifo_rd;
  logic              tx_busy;
  logic              tx_done;
  logic              tx;

  // Host side: FIFO head, baud strobe, configuration, line observer
  modport master (
    output s_tick, tx_start, tx_din, cfg_dbits, cfg_parity, cfg_stop, tx_break,
    input  tx_fifo_rd, tx_busy, tx_done, tx
  );

  // Transmitter side
  modport slave (
    input  s_tick, tx_start, tx_din, cfg_dbits, cfg_parity, cfg_stop, tx_break,
    output tx_fifo_rd, tx_busy, tx_done, tx
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DATA_W data bits, optional
// even/odd parity, 1/1.5/2 stop bits, back-to-back frames and line break.
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_cfg_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(3 * OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BRK_LAST  = CNT_W'(2 * OVERSAMPLE - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        nbit;
  logic [3:0]        f_dbits;
  logic [1:0]        f_stop;
  logic              f_par_en;
  logic              par_bit;
  logic              brk_stop;   // current STOP is the tail of a break, not a frame
  logic [DATA_W-1:0] shreg;
  logic              tx_q, busy_q, rd_q, done_q;

  logic [3:0]        ld_dbits;
  logic              ld_par_en, ld_par;
  logic [CNT_W-1:0]  stop_last;
  logic              frame_end, can_take, do_load, do_brk;

  // Decode configuration and parity for a word about to be loaded
  always_comb begin
    ld_dbits = bus.cfg_dbits;
    if (bus.cfg_dbits < 4'd5)                 ld_dbits = 4'd5;
    else if (bus.cfg_dbits > 4'(DATA_W))      ld_dbits = 4'(DATA_W);
    ld_par_en = (bus.cfg_parity == 2'b01) || (bus.cfg_parity == 2'b10);
    ld_par    = (bus.cfg_parity == 2'b10);
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(ld_dbits)) ld_par = ld_par ^ bus.tx_din[i];
  end

  // Last tick index of the stop period for the latched stop setting
  always_comb begin
    case (f_stop)
      2'b00:   stop_last = BIT_LAST;
      2'b01:   stop_last = HALF_LAST;
      default: stop_last = BRK_LAST;
    endcase
  end

  // IDLE and the final stop tick share the same load / break decision
  always_comb begin
    frame_end = (state == STOP) && (cnt == stop_last);
    can_take  = bus.s_tick && ((state == IDLE) || frame_end);
    do_brk    = can_take && bus.tx_break;
    do_load   = can_take && !bus.tx_break && bus.tx_start;
  end

  // Frame sequencer; everything advances on s_tick, strobes self-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      nbit     <= '0;
      f_dbits  <= '0;
      f_stop   <= '0;
      f_par_en <= 1'b0;
      par_bit  <= 1'b0;
      brk_stop <= 1'b0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      if (bus.s_tick) begin
        case (state)
          IDLE: ;
          START: begin
            if (cnt == BIT_LAST) begin
              state <= DATA;
              cnt   <= '0;
              tx_q  <= shreg[0];
            end else cnt <= cnt + 1'b1;
          end
          DATA: begin
            if (cnt == BIT_LAST) begin
              cnt <= '0;
              if (nbit == f_dbits - 4'd1) begin
                nbit  <= '0;
                state <= f_par_en ? PARITY : STOP;
                tx_q  <= f_par_en ? par_bit : 1'b1;
              end else begin
                shreg <= shreg >> 1;
                nbit  <= nbit + 1'b1;
                tx_q  <= shreg[1];
              end
            end else cnt <= cnt + 1'b1;
          end
          PARITY: begin
            if (cnt == BIT_LAST) begin
              state <= STOP;
              cnt   <= '0;
              tx_q  <= 1'b1;
            end else cnt <= cnt + 1'b1;
          end
          STOP: begin
            if (frame_end) begin
              cnt      <= '0;
              done_q   <= !brk_stop;
              brk_stop <= 1'b0;
              state    <= IDLE;
              busy_q   <= 1'b0;
            end else cnt <= cnt + 1'b1;
          end
          BREAK: begin
            // saturate so the minimum-length test stays true while held
            if (cnt != BRK_LAST) cnt <= cnt + 1'b1;
            if (!bus.tx_break && cnt == BRK_LAST) begin
              state    <= STOP;
              cnt      <= '0;
              tx_q     <= 1'b1;
              f_stop   <= 2'b00;
              brk_stop <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        // overrides the IDLE/STOP-end defaults above
        if (do_load) begin
          shreg    <= bus.tx_din;
          f_dbits  <= ld_dbits;
          f_par_en <= ld_par_en;
          par_bit  <= ld_par;
          f_stop   <= bus.cfg_stop;
          rd_q     <= 1'b1;
          state    <= START;
          cnt      <= '0;
          nbit     <= '0;
          tx_q     <= 1'b0;
          busy_q   <= 1'b1;
        end else if (do_brk) begin
          state  <= BREAK;
          cnt    <= '0;
          tx_q   <= 1'b0;
          busy_q <= 1'b1;
        end
      end
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_fifo_rd = rd_q;
  assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frames, queued words,
// random configurations with mid-frame config noise, break and reset.
module tb_uart_tx_cfg;
  localparam int DW = 8;
  localparam int OS = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    dbits;
    logic [1:0]    par;
    logic [1:0]    stop;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_W(DW)) bus();
  uart_tx_cfg #(.DATA_W(DW), .OVERSAMPLE(OS), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic o_tx, o_busy, o_done, o_rd, o_rd2, o_done2;
  frame_t fq[$];
  logic   exp_tx[$];
  int     starts[$];

  function automatic frame_t mk(logic [DW-1:0] d, logic [3:0] db, logic [1:0] p, logic [1:0] s);
    frame_t f;
    f.data = d; f.dbits = db; f.par = p; f.stop = s;
    return f;
  endfunction

  // Reference: expected line level for every tick of one frame
  function automatic int append_frame(frame_t f);
    int eff, ones, st, n;
    eff  = (f.dbits < 5) ? 5 : ((f.dbits > DW) ? DW : int'(f.dbits));
    ones = 0;
    n    = OS;
    repeat (OS) exp_tx.push_back(1'b0);
    for (int b = 0; b < eff; b++) begin
      repeat (OS) exp_tx.push_back(f.data[b]);
      ones += int'(f.data[b]);
      n += OS;
    end
    if (f.par == 2'd1 || f.par == 2'd2) begin
      repeat (OS) exp_tx.push_back((f.par == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0));
      n += OS;
    end
    st = (f.stop == 2'd0) ? OS : ((f.stop == 2'd1) ? OS * 3 / 2 : 2 * OS);
    repeat (st) exp_tx.push_back(1'b1);
    return n + st;
  endfunction

  function automatic bit is_start(int e);
    foreach (starts[i]) if (starts[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_cfg(frame_t f);
    bus.cfg_dbits = f.dbits; bus.cfg_parity = f.par; bus.cfg_stop = f.stop;
  endtask

  task automatic rand_cfg();
    bus.cfg_dbits  = 4'($urandom_range(0, 15));
    bus.cfg_parity = 2'($urandom_range(0, 3));
    bus.cfg_stop   = 2'($urandom_range(0, 3));
  endtask

  // One baud tick, then one plain clock to see strobes self-clear
  task automatic step();
    bus.s_tick = 1'b1;
    @(posedge clk); #1;
    bus.s_tick = 1'b0;
    o_tx = bus.tx; o_busy = bus.tx_busy; o_done = bus.tx_done; o_rd = bus.tx_fifo_rd;
    @(posedge clk); #1;
    o_rd2 = bus.tx_fifo_rd; o_done2 = bus.tx_done;
  endtask

  // Plays the frames in fq through a FIFO model and checks every tick
  task automatic run_frames(string name);
    int   total;
    logic et, eb, ed, er;
    exp_tx.delete(); starts.delete(); total = 0;
    foreach (fq[i]) begin
      starts.push_back(total);
      total += append_frame(fq[i]);
    end
    bus.tx_start = 1'b1; bus.tx_din = fq[0].data; set_cfg(fq[0]);
    for (int e = 0; e <= total + 3; e++) begin
      step();
      er = is_start(e);
      ed = (e > 0) && (is_start(e) || e == total);
      et = (e < total) ? exp_tx[e] : 1'b1;
      eb = (e < total);
      checks++; if (o_tx !== et) begin errors++; $display("FAIL %s tx e=%0d got %b want %b", name, e, o_tx, et); end
      checks++; if (o_busy !== eb) begin errors++; $display("FAIL %s busy e=%0d got %b want %b", name, e, o_busy, eb); end
      checks++; if (o_done !== ed) begin errors++; $display("FAIL %s done e=%0d got %b want %b", name, e, o_done, ed); end
      checks++; if (o_rd !== er) begin errors++; $display("FAIL %s fifo_rd e=%0d got %b want %b", name, e, o_rd, er); end
      checks++; if (o_rd2 !== 1'b0 || o_done2 !== 1'b0) begin
        errors++; $display("FAIL %s strobe_clear e=%0d got rd=%b done=%b want 0 0", name, e, o_rd2, o_done2);
      end
      if (o_rd && fq.size() > 0) void'(fq.pop_front());
      bus.tx_start = (fq.size() > 0);
      if (fq.size() > 0) bus.tx_din = fq[0].data;
      if (fq.size() > 0 && is_start(e + 1)) set_cfg(fq[0]);
      else rand_cfg();
    end
    fq.delete();
    bus.tx_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_tick = 1'b0; bus.tx_start = 1'b1; bus.tx_din = 8'hA5; bus.tx_break = 1'b0;
    set_cfg(mk(8'h00, 4'd8, 2'd0, 2'd0));
    reset_n = 1'b0;
    step(); step();
    checks++; if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_rd !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL reset_state got tx=%b busy=%b rd=%b done=%b want 1 0 0 0", o_tx, o_busy, o_rd, o_done);
    end
    bus.tx_start = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    fq.push_back(mk(8'h55, 4'd8, 2'd0, 2'd0)); run_frames("8n1_55");
    fq.push_back(mk(8'h41, 4'd7, 2'd1, 2'd2)); run_frames("7e2_41");
    fq.push_back(mk(8'hFF, 4'd8, 2'd2, 2'd1)); run_frames("8o15_ff");
    fq.push_back(mk(8'hE6, 4'd3, 2'd1, 2'd0)); run_frames("dbits3_clamp");
    fq.push_back(mk(8'h5A, 4'd12, 2'd2, 2'd3)); run_frames("dbits12_clamp");
  endtask

  task automatic test_back_to_back();
    fq.push_back(mk(8'h12, 4'd8, 2'd0, 2'd0));
    fq.push_back(mk(8'hC7, 4'd6, 2'd2, 2'd2));
    fq.push_back(mk(8'h3C, 4'd8, 2'd1, 2'd1));
    run_frames("three_queued");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        fq.push_back(mk(DW'($urandom), 4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))));
      run_frames("random");
    end
  endtask

  task automatic test_break(int b);
    int L, low;
    logic seen_hi;
    exp_tx.delete();
    L = append_frame(mk(8'hA5, 4'd8, 2'd0, 2'd0));
    bus.tx_start = 1'b1; bus.tx_din = 8'hA5; set_cfg(mk(8'h00, 4'd8, 2'd0, 2'd0));
    for (int e = 0; e < L; e++) begin
      step();
      if (e == 0) bus.tx_start = 1'b0;
      if (e == 40) bus.tx_break = 1'b1;
      checks++; if (o_tx !== exp_tx[e]) begin errors++; $display("FAIL break_frame tx e=%0d got %b want %b", e, o_tx, exp_tx[e]); end
    end
    bus.tx_start = 1'b1; bus.tx_din = 8'h99;   // word waiting must not be popped
    step();
    checks++; if (o_done !== 1'b1 || o_tx !== 1'b0 || o_busy !== 1'b1 || o_rd !== 1'b0) begin
      errors++; $display("FAIL break_enter got done=%b tx=%b busy=%b rd=%b want 1 0 1 0", o_done, o_tx, o_busy, o_rd);
    end
    low = 1; seen_hi = 1'b0;
    for (int k = 1; k <= 300 && !seen_hi; k++) begin
      if (k == b + 1) bus.tx_break = 1'b0;
      step();
      checks++; if (o_rd !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
        errors++; $display("FAIL break_hold k=%0d got rd=%b done=%b busy=%b want 0 0 1", k, o_rd, o_done, o_busy);
      end
      if (o_tx === 1'b1) seen_hi = 1'b1; else low++;
    end
    bus.tx_start = 1'b0;
    checks++; if (!seen_hi || low != ((b + 1 > 2 * OS) ? b + 1 : 2 * OS)) begin
      errors++; $display("FAIL break_len got %0d low ticks (released=%b) want %0d", low, seen_hi, (b + 1 > 2 * OS) ? b + 1 : 2 * OS);
    end
    for (int j = 1; j <= OS; j++) begin
      step();
      checks++; if (o_tx !== 1'b1 || o_busy !== (j < OS)) begin
        errors++; $display("FAIL break_stop j=%0d got tx=%b busy=%b want 1 %b", j, o_tx, o_busy, j < OS);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.tx_start = 1'b1; bus.tx_din = 8'hC3; set_cfg(mk(8'h00, 4'd8, 2'd0, 2'd0));
    step();
    bus.tx_start = 1'b0;
    repeat (50) step();   // inside data bit 2, which is 0
    checks++; if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset got tx=%b busy=%b want 0 1", o_tx, o_busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got tx=%b busy=%b want 1 0", bus.tx, bus.tx_busy);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    fq.push_back(mk(8'h96, 4'd8, 2'd1, 2'd0));
    run_frames("post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_break($urandom_range(3, 20));
    test_break($urandom_range(40, 60));
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
